// File: rtl/odo_scan_pkg.sv
// Shared definitions for the odometer scan controller: bus size, FSM
// state encoding, stress_cfg bit positions and the timer width.
package odo_scan_pkg;

    localparam int NUM_ODOMETER = 21;

    localparam int TIMER_W = 8;

    // Bit positions inside the 5-bit stress_cfg word.
    localparam int STRESS_BIT   = 4;
    localparam int AC_DC_BIT    = 3;
    localparam int SEL_INV_BIT  = 2;
    localparam int SEL_NAND_BIT = 1;
    localparam int SEL_NOR_BIT  = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PROG    = 3'd1,
        ST_LOAD    = 3'd2,
        ST_TRIG    = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_HOLD    = 3'd6
    } scan_state_t;

    // A zero trigger width would never trigger the odometer, so it is
    // promoted to a single cycle.
    function automatic logic [TIMER_W-1:0] eff_meas(input logic [TIMER_W-1:0] m);
        return (m == '0) ? TIMER_W'(1) : m;
    endfunction

endpackage

// File: rtl/odo_scan_timer.sv
// Down-counting phase timer. Loading N makes expire rise during the N-th
// cycle after the load edge; the count parks at zero instead of wrapping.
module odo_scan_timer
    import odo_scan_pkg::*;
(
    input  logic               stream_clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    output logic               expire
);

    logic [TIMER_W-1:0] count_q;

    // Reload on request, otherwise count down and saturate at zero.
    always_ff @(posedge stream_clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

    assign expire = (count_q <= TIMER_W'(1));

endmodule

// File: rtl/odometer_scan_ctrl.sv
// Odometer scan controller: walks an inclusive range of odometers on the
// shared bus, programs, loads, triggers and reads each one, and hands the
// {idx, count} results out through a valid/ready port.
module odometer_scan_ctrl #(
    parameter int NUM_ODOMETER = odo_scan_pkg::NUM_ODOMETER,
    parameter int SEL_W        = 5,
    parameter int COUNT_W      = 12
) (
    input  logic                     stream_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [SEL_W-1:0]         first_idx,
    input  logic [SEL_W-1:0]         last_idx,
    input  logic [4:0]               stress_cfg,
    input  logic [7:0]               meas_cycles,
    input  logic [7:0]               settle_cycles,
    output logic [SEL_W-1:0]         odometer_sel,
    output logic                     odometer_enable,
    output logic                     stress,
    output logic                     ac_dc,
    output logic                     sel_inv,
    output logic                     sel_nand,
    output logic                     sel_nor,
    output logic                     odometer_meas_trig,
    output logic                     odometer_load,
    input  logic [COUNT_W-1:0]       bit_count,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [SEL_W+COUNT_W-1:0] res_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    import odo_scan_pkg::*;

    scan_state_t state;

    logic [SEL_W-1:0]         idx_q;
    logic [SEL_W-1:0]         last_q;
    logic [4:0]               cfg_q;
    logic [TIMER_W-1:0]       meas_q;
    logic [TIMER_W-1:0]       settle_q;

    logic [SEL_W-1:0]         sel_q;
    logic                     enable_q;
    logic [4:0]               stress_q;
    logic                     trig_q;
    logic                     load_q;
    logic                     res_valid_q;
    logic [SEL_W+COUNT_W-1:0] res_data_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;

    logic                     range_ok;
    logic                     timer_load;
    logic [TIMER_W-1:0]       timer_value;
    logic                     timer_expire;

    // A range is usable when it is ordered and ends on an existing odometer.
    always_comb begin
        range_ok = (first_idx <= last_idx) && (int'(last_idx) < NUM_ODOMETER);
    end

    // Arm the timer on the edge that enters a timed phase: the trigger
    // width while leaving LOAD, the settle wait while leaving TRIG.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        if (state == ST_LOAD) begin
            timer_load  = 1'b1;
            timer_value = meas_q;
        end else if (state == ST_TRIG && timer_expire) begin
            timer_load  = 1'b1;
            timer_value = settle_q;
        end
    end

    odo_scan_timer u_timer (
        .stream_clk (stream_clk),
        .reset      (reset),
        .load       (timer_load),
        .value      (timer_value),
        .expire     (timer_expire)
    );

    // Scan sequencer; every output is a register written on the edge that
    // enters the state it belongs to, so bit_count only reaches res_data.
    always_ff @(posedge stream_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            cfg_q       <= '0;
            meas_q      <= '0;
            settle_q    <= '0;
            sel_q       <= '0;
            enable_q    <= 1'b0;
            stress_q    <= '0;
            trig_q      <= 1'b0;
            load_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state != ST_IDLE && abort) begin
                state       <= ST_IDLE;
                sel_q       <= '0;
                enable_q    <= 1'b0;
                stress_q    <= '0;
                trig_q      <= 1'b0;
                load_q      <= 1'b0;
                res_valid_q <= 1'b0;
                res_data_q  <= '0;
                busy_q      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            if (range_ok) begin
                                idx_q    <= first_idx;
                                last_q   <= last_idx;
                                cfg_q    <= stress_cfg;
                                meas_q   <= eff_meas(meas_cycles);
                                settle_q <= settle_cycles;
                                sel_q    <= first_idx;
                                enable_q <= 1'b1;
                                stress_q <= stress_cfg;
                                busy_q   <= 1'b1;
                                state    <= ST_PROG;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    ST_PROG: begin
                        enable_q <= 1'b0;
                        stress_q <= '0;
                        load_q   <= 1'b1;
                        state    <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        load_q <= 1'b0;
                        trig_q <= 1'b1;
                        state  <= ST_TRIG;
                    end
                    ST_TRIG: begin
                        if (timer_expire) begin
                            trig_q <= 1'b0;
                            state  <= (settle_q == '0) ? ST_CAPTURE : ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (timer_expire) begin
                            state <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        res_data_q  <= {idx_q, bit_count};
                        res_valid_q <= 1'b1;
                        sel_q       <= '0;
                        state       <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (res_ready) begin
                            res_valid_q <= 1'b0;
                            if (idx_q == last_q) begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                                state  <= ST_IDLE;
                            end else begin
                                idx_q    <= idx_q + SEL_W'(1);
                                sel_q    <= idx_q + SEL_W'(1);
                                enable_q <= 1'b1;
                                stress_q <= cfg_q;
                                state    <= ST_PROG;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign odometer_sel       = sel_q;
    assign odometer_enable    = enable_q;
    assign stress             = stress_q[STRESS_BIT];
    assign ac_dc              = stress_q[AC_DC_BIT];
    assign sel_inv            = stress_q[SEL_INV_BIT];
    assign sel_nand           = stress_q[SEL_NAND_BIT];
    assign sel_nor            = stress_q[SEL_NOR_BIT];
    assign odometer_meas_trig = trig_q;
    assign odometer_load      = load_q;
    assign res_valid          = res_valid_q;
    assign res_data           = res_data_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;

endmodule
